clk_rst_ctrl: RTL and testbench

//  Clock-enable and reset sequencer for the SoC core, running entirely on the FPGA clock CLK.
//  - Generates a one-cycle tick enable at a runtime-programmable divide ratio (replaces rippled slow clocks).
//  - Holds core_rstn low for a fixed count after reset or soft reset.
//  - Arbitrates divide-ratio changes, halt and soft-reset requests so that each takes effect only on a tick boundary.

---
 rtl/clk_rst_pkg.sv | 24 ++
 rtl/clk_en_counter.sv | 47 ++++
 rtl/clk_rst_ctrl.sv | 155 +++++++++++++++
 tb/tb_clk_rst_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// Shared types and constants for the clock-enable / reset sequencer.
package clk_rst_pkg;

    // Sequencer phases: core held in reset, ticking, or ticks suspended.
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } crc_state_t;

    // Output levels, named so the FSM reads in terms of intent.
    localparam logic TICK_ON      = 1'b1;
    localparam logic TICK_OFF     = 1'b0;
    localparam logic ACK_ON       = 1'b1;
    localparam logic ACK_OFF      = 1'b0;
    localparam logic CORE_RST_ON  = 1'b0;
    localparam logic CORE_RST_OFF = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_en_counter.sv
// Loadable down-counter producing a registered tick in every cycle in which
// the count is zero while the counter is active (loaded or counting).
module clk_en_counter
    import clk_rst_pkg::*;
#(
    parameter int           W    = 8,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         CLK,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tick
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tick_q, tick_d;

    // Next count: a load wins over a decrement; otherwise the count is frozen.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = TICK_OFF;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q - W'(1);
        end
        if ((load || en) && (cnt_d == '0)) begin
            tick_d = TICK_ON;
        end
    end

    // Count and tick registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            cnt_q  <= INIT;
            tick_q <= TICK_OFF;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/clk_rst_ctrl.sv
// Clock-enable and core-reset sequencer. Divide-ratio changes, halt and
// soft-reset requests are only honoured on tick boundaries (or, for divide
// changes, at any cycle while halted).
module clk_rst_ctrl
    import clk_rst_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 15,
    parameter int RST_HOLD    = 16
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic             soft_rst,
    input  logic             halt_req,
    output logic             halt_ack,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    output logic             tick,
    output logic             core_rstn,
    output logic [DIV_W-1:0] div_cur
);

    localparam int                HOLD_W    = cnt_width(RST_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    crc_state_t        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [DIV_W-1:0]  div_reg_q, div_reg_d;
    logic              div_ack_q, div_ack_d;
    logic              halt_ack_q, halt_ack_d;
    logic              core_rstn_q, core_rstn_d;

    logic              cnt_load;
    logic [DIV_W-1:0]  cnt_load_val;
    logic              cnt_en;

    // A divide request is taken at most once: the requester still holds it
    // high in the cycle the ack is visible.
    logic div_take;
    assign div_take = div_req && !div_ack_q;

    clk_en_counter #(
        .W    (DIV_W),
        .INIT (DIV_W'(DIV_DEFAULT))
    ) u_cnt (
        .CLK      (CLK),
        .resetn   (resetn),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .tick     (tick)
    );

    // Next-state and registered-output logic; tick marks the cycle where
    // requests may be sampled in RUN.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        div_reg_d    = div_reg_q;
        div_ack_d    = ACK_OFF;
        halt_ack_d   = halt_ack_q;
        core_rstn_d  = core_rstn_q;
        cnt_load     = 1'b0;
        cnt_load_val = div_reg_q;
        cnt_en       = 1'b0;
        case (state_q)
            HOLD: begin
                core_rstn_d = CORE_RST_ON;
                halt_ack_d  = ACK_OFF;
                if (soft_rst) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = RUN;
                    hold_cnt_d  = '0;
                    core_rstn_d = CORE_RST_OFF;
                    cnt_load    = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RUN: begin
                if (tick) begin
                    if (soft_rst) begin
                        state_d     = HOLD;
                        hold_cnt_d  = '0;
                        core_rstn_d = CORE_RST_ON;
                    end else if (halt_req) begin
                        state_d    = HALT;
                        halt_ack_d = ACK_ON;
                    end else begin
                        cnt_load = 1'b1;
                        if (div_take) begin
                            div_reg_d    = div_val;
                            cnt_load_val = div_val;
                            div_ack_d    = ACK_ON;
                        end
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            HALT: begin
                if (soft_rst) begin
                    state_d     = HOLD;
                    hold_cnt_d  = '0;
                    core_rstn_d = CORE_RST_ON;
                    halt_ack_d  = ACK_OFF;
                end else begin
                    if (div_take) begin
                        div_reg_d    = div_val;
                        cnt_load_val = div_val;
                        div_ack_d    = ACK_ON;
                    end
                    if (!halt_req) begin
                        state_d    = RUN;
                        halt_ack_d = ACK_OFF;
                        cnt_load   = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = HOLD;
                hold_cnt_d  = '0;
                core_rstn_d = CORE_RST_ON;
                halt_ack_d  = ACK_OFF;
            end
        endcase
    end

    // State and output registers; resetn overrides every request.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q     <= HOLD;
            hold_cnt_q  <= '0;
            div_reg_q   <= DIV_W'(DIV_DEFAULT);
            div_ack_q   <= ACK_OFF;
            halt_ack_q  <= ACK_OFF;
            core_rstn_q <= CORE_RST_ON;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            div_reg_q   <= div_reg_d;
            div_ack_q   <= div_ack_d;
            halt_ack_q  <= halt_ack_d;
            core_rstn_q <= core_rstn_d;
        end
    end

    assign halt_ack  = halt_ack_q;
    assign div_ack   = div_ack_q;
    assign core_rstn = core_rstn_q;
    assign div_cur   = div_reg_q;

endmodule

// File: tb/tb_clk_rst_ctrl.sv
// Testbench for clk_rst_ctrl: directed scenarios followed by randomized
// requests, every cycle compared against a cycle-level behavioural model.
module tb_clk_rst_ctrl;

    localparam int DIV_W       = 8;
    localparam int DIV_DEFAULT = 15;
    localparam int RST_HOLD    = 16;

    logic             CLK = 1'b0;
    logic             resetn   = 1'b0;
    logic             soft_rst = 1'b0;
    logic             halt_req = 1'b0;
    logic             div_req  = 1'b0;
    logic [DIV_W-1:0] div_val  = '0;
    logic             halt_ack;
    logic             div_ack;
    logic             tick;
    logic             core_rstn;
    logic [DIV_W-1:0] div_cur;

    always #5 CLK = ~CLK;

    clk_rst_ctrl #(
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEFAULT),
        .RST_HOLD    (RST_HOLD)
    ) dut (
        .CLK       (CLK),
        .resetn    (resetn),
        .soft_rst  (soft_rst),
        .halt_req  (halt_req),
        .halt_ack  (halt_ack),
        .div_req   (div_req),
        .div_val   (div_val),
        .div_ack   (div_ack),
        .tick      (tick),
        .core_rstn (core_rstn),
        .div_cur   (div_cur)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Behavioural model: cycles of core reset still to serve, halted flag,
    // cycles until the next tick, programmed ratio, ack pulse.
    bit m_rstn    = 1'b0;
    int m_left    = RST_HOLD;
    bit m_halted  = 1'b0;
    int m_to_tick = DIV_DEFAULT;
    int m_div     = DIV_DEFAULT;
    bit m_ack     = 1'b0;
    bit exp_tick  = 1'b0;

    bit drop_div  = 1'b0;
    int tick_log[$];
    int rise_cyc  = -1;
    int low_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Advance the model over one clock edge using the inputs now on the pins.
    task automatic model_step();
        bit ack_n = 1'b0;
        if (!resetn) begin
            m_rstn = 1'b0; m_left = RST_HOLD; m_halted = 1'b0;
            m_div = DIV_DEFAULT; m_to_tick = DIV_DEFAULT; m_ack = 1'b0;
            return;
        end
        if (!m_rstn) begin
            if (soft_rst) m_left = RST_HOLD;
            else begin
                m_left--;
                if (m_left == 0) begin
                    m_rstn = 1'b1;
                    m_to_tick = m_div;
                end
            end
        end else if (m_halted) begin
            if (soft_rst) begin
                m_halted = 1'b0; m_rstn = 1'b0; m_left = RST_HOLD;
            end else begin
                if (div_req && !m_ack) begin
                    m_div = int'(div_val); ack_n = 1'b1;
                end
                if (!halt_req) begin
                    m_halted = 1'b0; m_to_tick = m_div;
                end
            end
        end else if (m_to_tick == 0) begin
            if (soft_rst) begin
                m_rstn = 1'b0; m_left = RST_HOLD;
            end else if (halt_req) begin
                m_halted = 1'b1;
            end else begin
                if (div_req && !m_ack) begin
                    m_div = int'(div_val); ack_n = 1'b1;
                end
                m_to_tick = m_div;
            end
        end else begin
            m_to_tick--;
        end
        m_ack = ack_n;
    endtask

    // One clock: update model, clock, compare all outputs, service requester.
    task automatic run_cycle();
        model_step();
        @(posedge CLK);
        #1;
        cyc++;
        exp_tick = m_rstn && !m_halted && (m_to_tick == 0);
        chk("tick",      {31'd0, tick},      {31'd0, exp_tick});
        chk("div_ack",   {31'd0, div_ack},   {31'd0, m_ack});
        chk("halt_ack",  {31'd0, halt_ack},  {31'd0, m_halted});
        chk("core_rstn", {31'd0, core_rstn}, {31'd0, m_rstn});
        chk("div_cur",   {24'd0, div_cur},   32'(m_div));
        if (tick === 1'b1) tick_log.push_back(cyc);
        if (core_rstn === 1'b1 && rise_cyc < 0) rise_cyc = cyc;
        if (core_rstn === 1'b0) low_cnt++;
        if (m_ack) $display("cycle %0d: divide ratio %0d loaded", cyc, m_div);
        if (drop_div) begin
            div_req  = 1'b0;
            drop_div = 1'b0;
        end
        if (m_ack) drop_div = 1'b1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic do_reset();
        resetn = 1'b0; soft_rst = 1'b0; halt_req = 1'b0; div_req = 1'b0;
        drop_div = 1'b0;
        run_n(2);
        resetn = 1'b1;
        cyc = 0;
        rise_cyc = -1;
        tick_log.delete();
    endtask

    function automatic int last_gap();
        int n = tick_log.size();
        return (n >= 2) ? tick_log[n-1] - tick_log[n-2] : -1;
    endfunction

    initial begin
        int t_wait;
        do_reset();
        chk("rst_tick",  {31'd0, tick},      32'd0);
        chk("rst_ack",   {31'd0, div_ack},   32'd0);
        chk("rst_halt",  {31'd0, halt_ack},  32'd0);
        chk("rst_rstn",  {31'd0, core_rstn}, 32'd0);
        chk("rst_div",   {24'd0, div_cur},   32'd15);

        // Reset release with the default ratio.
        run_n(66);
        chk("rise_cyc", 32'(rise_cyc), 32'd16);
        chk("tick_1st", 32'(tick_log.size() > 0 ? tick_log[0] : -1), 32'd31);
        chk("tick_2nd", 32'(tick_log.size() > 1 ? tick_log[1] : -1), 32'd47);
        chk("tick_3rd", 32'(tick_log.size() > 2 ? tick_log[2] : -1), 32'd63);

        // Ratio change to 3 while running.
        div_val = 8'd3; div_req = 1'b1;
        run_n(20);
        tick_log.delete();
        run_n(20);
        chk("div3_cur", {24'd0, div_cur}, 32'd3);
        chk("div3_gap", 32'(last_gap()), 32'd4);

        // Ratio 0 ticks every cycle; halt suppresses ticks.
        div_val = 8'd0; div_req = 1'b1;
        run_n(10);
        tick_log.delete();
        run_n(8);
        chk("div0_ticks", 32'(tick_log.size()), 32'd8);
        halt_req = 1'b1;
        run_n(4);
        tick_log.delete();
        run_n(6);
        chk("halt_quiet", 32'(tick_log.size()), 32'd0);
        chk("halt_ack_hi", {31'd0, halt_ack}, 32'd1);
        halt_req = 1'b0;
        run_n(6);

        // Halt and ratio change requested together.
        div_val = 8'd5; div_req = 1'b1; halt_req = 1'b1;
        run_n(12);
        chk("hd_cur",  {24'd0, div_cur},  32'd5);
        chk("hd_halt", {31'd0, halt_ack}, 32'd1);
        halt_req = 1'b0;
        tick_log.delete();
        run_n(24);
        chk("hd_gap", 32'(last_gap()), 32'd6);

        // Soft reset pulse on a tick.
        t_wait = 0;
        while (!exp_tick && t_wait < 50) begin
            run_cycle();
            t_wait++;
        end
        chk("wait_tick", {31'd0, exp_tick}, 32'd1);
        low_cnt = 0;
        soft_rst = 1'b1;
        run_cycle();
        soft_rst = 1'b0;
        run_n(30);
        chk("soft_low", 32'(low_cnt), 32'd16);
        chk("soft_div", {24'd0, div_cur}, 32'd5);

        // Reset while halted with a ratio request pending.
        halt_req = 1'b1;
        run_n(12);
        div_val = 8'd7; div_req = 1'b1; resetn = 1'b0;
        run_n(2);
        chk("r6_tick", {31'd0, tick},      32'd0);
        chk("r6_ack",  {31'd0, div_ack},   32'd0);
        chk("r6_halt", {31'd0, halt_ack},  32'd0);
        chk("r6_rstn", {31'd0, core_rstn}, 32'd0);
        chk("r6_div",  {24'd0, div_cur},   32'd15);
        div_req = 1'b0; drop_div = 1'b0; halt_req = 1'b0; resetn = 1'b1;

        // Randomized request traffic.
        for (int i = 0; i < 4000; i++) begin
            if (!resetn) begin
                resetn = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                resetn = 1'b0; div_req = 1'b0; drop_div = 1'b0;
            end
            if (soft_rst) soft_rst = ($urandom_range(0, 1) == 0);
            else          soft_rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 24) == 0) halt_req = ~halt_req;
            if (!div_req && !drop_div && $urandom_range(0, 7) == 0) begin
                div_val = DIV_W'($urandom_range(0, 9));
                div_req = 1'b1;
            end
            run_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
